// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: launches, places and retires a pool of falling
// enemy-car sprites; counts dodged enemies and freezes play on collision.
// Ports:
//   logic_clk, reset (sync, active-high), start (pulse), collision (level)
//   pos_y    : packed 10-bit y per unit (slot i = [10i+9:10i])
//   enemy_en : per-unit enable
//   enemy_x  : packed 10-bit x offset per unit
//   score    : dodged count, saturating
//   game_over: high in FREEZE
//   running  : high in RUN
module enemy_spawn_scheduler #(
  parameter int unsigned N_ENEMY   = 3,
  parameter logic [9:0]  LANE0_X   = 10'd160,
  parameter logic [9:0]  LANE_W    = 10'd80,
  parameter logic [15:0] SPAWN_GAP = 16'd90,
  parameter logic [9:0]  Y_EXIT    = 10'd600
) (
  input  logic                   logic_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   collision,
  input  logic [10*N_ENEMY-1:0]  pos_y,
  output logic [N_ENEMY-1:0]     enemy_en,
  output logic [10*N_ENEMY-1:0]  enemy_x,
  output logic [15:0]            score,
  output logic                   game_over,
  output logic                   running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [N_ENEMY-1:0]     r_en;
  logic [10*N_ENEMY-1:0]  r_x;
  logic [15:0]            r_score;
  logic [15:0]            r_gap;
  logic [7:0]             r_lfsr;
  logic [1:0]             r_last_lane;

  state_t                 w_state_nxt;
  logic [N_ENEMY-1:0]     w_en_nxt;
  logic [10*N_ENEMY-1:0]  w_x_nxt;
  logic [15:0]            w_score_nxt;
  logic [15:0]            w_gap_nxt;
  logic [7:0]             w_lfsr_nxt;
  logic [1:0]             w_last_nxt;

  logic [N_ENEMY-1:0]     w_retire;
  logic [3:0]             w_ret_cnt;
  logic [16:0]            w_score_sum;
  logic [15:0]            w_score_sat;
  logic [N_ENEMY-1:0]     w_spawn_mask;
  logic                   w_found;
  logic [1:0]             w_lane_raw;
  logic [1:0]             w_lane;
  logic [9:0]             w_lane_x;
  logic                   w_fb;

  // Retire detection and per-cycle retire count
  always_comb begin
    w_retire  = '0;
    w_ret_cnt = '0;
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      w_retire[i] = r_en[i] && (pos_y[10*i +: 10] == Y_EXIT);
      w_ret_cnt   = w_ret_cnt + 4'(w_retire[i]);
    end
  end

  assign w_score_sum = {1'b0, r_score} + {13'b0, w_ret_cnt};
  assign w_score_sat = w_score_sum[16] ? 16'hFFFF
                                       : w_score_sum[15:0];

  // Lowest free slot; a retiring slot is still enabled, so it
  // can never be picked in the same cycle it leaves.
  always_comb begin
    w_spawn_mask = '0;
    w_found      = 1'b0;
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      if (!r_en[i] && !w_found) begin
        w_spawn_mask[i] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  // Never reuse the previous lane twice in a row
  assign w_lane_raw = r_lfsr[1:0];
  assign w_lane     = (w_lane_raw == r_last_lane) ? w_lane_raw + 2'd1
                                                  : w_lane_raw;
  assign w_lane_x   = LANE0_X + ({8'b0, w_lane} * LANE_W);

  // Taps 8,6,5,4 map to bits 7,5,4,3
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_x_nxt     = r_x;
    w_score_nxt = r_score;
    w_gap_nxt   = r_gap;
    w_lfsr_nxt  = r_lfsr;
    w_last_nxt  = r_last_lane;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Collision wins: the whole cycle's updates are discarded
        if (collision) begin
          w_state_nxt = S_FREEZE;
        end else begin
          w_en_nxt    = r_en & ~w_retire;
          w_score_nxt = w_score_sat;
          w_lfsr_nxt  = {r_lfsr[6:0], w_fb};
          if (r_gap == 16'd0) begin
            w_gap_nxt = SPAWN_GAP - 16'd1;
            if (w_found) begin
              w_en_nxt   = w_en_nxt | w_spawn_mask;
              w_last_nxt = w_lane;
              for (int i = 0; i < int'(N_ENEMY); i++) begin
                if (w_spawn_mask[i]) w_x_nxt[10*i +: 10] = w_lane_x;
              end
            end
          end else begin
            w_gap_nxt = r_gap - 16'd1;
          end
        end
      end
      S_FREEZE: begin
        w_state_nxt = S_FREEZE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_en        <= '0;
      r_x         <= {N_ENEMY{LANE0_X}};
      r_score     <= '0;
      r_gap       <= SPAWN_GAP - 16'd1;
      r_lfsr      <= 8'hA5;
      r_last_lane <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_en        <= w_en_nxt;
      r_x         <= w_x_nxt;
      r_score     <= w_score_nxt;
      r_gap       <= w_gap_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_last_lane <= w_last_nxt;
    end
  end

  assign enemy_en  = r_en;
  assign enemy_x   = r_x;
  assign score     = r_score;
  assign game_over = (r_state == S_FREEZE);
  assign running   = (r_state == S_RUN);

endmodule
